// File: rtl/tdc_regmap_pkg.sv
// Shared register-map constants and sequencer state encoding for the TDC
// readout path; also used by gen_sel_signals.
package tdc_regmap_pkg;

  localparam int FIRST_ADDR = 0;
  localparam int LAST_ADDR  = 23;
  localparam int IDLE_ADDR  = 31;

  localparam int ADDR_FPGA  = 0;
  localparam int ADDR_VER0  = 1;
  localparam int ADDR_PENC  = 6;
  localparam int ADDR_CNTR0 = 7;
  localparam int ADDR_DAC   = 23;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/tdc_readout_seq.sv
// Walks the TDC register map once per frame, waits for the byte mux to settle
// at each address and streams the captured byte out over valid/ready.
module tdc_readout_seq #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int FIRST_ADDR = tdc_regmap_pkg::FIRST_ADDR,
  parameter int LAST_ADDR  = tdc_regmap_pkg::LAST_ADDR,
  parameter int IDLE_ADDR  = tdc_regmap_pkg::IDLE_ADDR,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic              busy,
  output logic              done
);

  import tdc_regmap_pkg::seq_state_t;
  import tdc_regmap_pkg::IDLE;
  import tdc_regmap_pkg::SETTLE;
  import tdc_regmap_pkg::SEND;
  import tdc_regmap_pkg::DONE;

  localparam logic [ADDR_W-1:0] A_FIRST  = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] A_LAST   = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] A_IDLE   = ADDR_W'(IDLE_ADDR);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYC);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= A_IDLE;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      // A byte on offer in this cycle is dropped, not counted as transferred.
      state     <= IDLE;
      addr      <= A_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr  <= A_FIRST;
            cnt   <= CNT_LOAD;
            busy  <= 1'b1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          // data_in is only trusted once the mux has had cnt cycles to settle.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            out_data  <= data_in;
            out_valid <= 1'b1;
            out_sof   <= (addr == A_FIRST);
            out_eof   <= (addr == A_LAST);
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            if (addr == A_LAST) begin
              addr  <= A_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              addr  <= addr + 1'b1;
              cnt   <= CNT_LOAD;
              state <= SETTLE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/tdc_readout_seq.md
Name: tdc_readout_seq

Overview:
- Readout sequencer that drives the 5-bit register address into the gen_sel_signals decoder and its byte mux.
- Per frame, walks the fixed readout map in order:
  - addr 0: FPGA id byte
  - addr 1-5: version bytes
  - addr 6: priority-encoder byte
  - addr 7-22: 16 counter bytes
  - addr 23: DAC byte
- For each address, waits for mux settling, captures the selected byte and hands it downstream over a valid/ready stream.
- Sits between the TDC register/mux layer and the host-link transmitter.

Parameters:
- ADDR_W, 5, address width into gen_sel_signals.
- DATA_W, 8, width of the muxed register byte.
- FIRST_ADDR, 0, first address of a frame.
- LAST_ADDR, 23, last address of a frame (DAC byte).
- IDLE_ADDR, 31, address driven while idle; decodes to no select.
- SETTLE_CYC, 2, extra wait cycles after an address change before capture; legal range 0..15.
- CNT_W, 4, settle counter width.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request one readout frame; sampled only in IDLE.
- abort, input, 1, synchronous frame cancel; higher priority than everything except rst_n.
- addr, output, ADDR_W, register address to gen_sel_signals.
- data_in, input, DATA_W, byte selected by the decoder/mux for the current addr.
- out_data, output, DATA_W, captured byte.
- out_valid, output, 1, out_data is valid.
- out_ready, input, 1, downstream accepts the byte.
- out_sof, output, 1, qualifies the byte for FIRST_ADDR; meaningful only with out_valid.
- out_eof, output, 1, qualifies the byte for LAST_ADDR; meaningful only with out_valid.
- busy, output, 1, frame in progress.
- done, output, 1, one-cycle pulse at frame completion.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, addr=IDLE_ADDR, out_data=0.
  - out_valid, out_sof, out_eof, busy, done all 0.
  - cnt=0.
- IDLE:
  - addr=IDLE_ADDR, busy=0.
  - start=1 -> addr=FIRST_ADDR, cnt=SETTLE_CYC, busy=1, go to SETTLE.
- SETTLE:
  - If cnt!=0: cnt decrements.
  - If cnt==0: out_data<=data_in, out_valid<=1, out_sof<=(addr==FIRST_ADDR), out_eof<=(addr==LAST_ADDR), go to SEND.
  - SETTLE therefore lasts SETTLE_CYC+1 cycles.
- SEND:
  - out_data, out_sof, out_eof and addr are held stable while out_valid=1 and out_ready=0. No timeout.
  - On a cycle with out_valid=1 and out_ready=1:
    - out_valid, out_sof, out_eof <= 0.
    - If addr==LAST_ADDR: addr=IDLE_ADDR, go to DONE.
    - Else: addr=addr+1, cnt=SETTLE_CYC, go to SETTLE.
- DONE:
  - done=1 for exactly one cycle, busy=0, go to IDLE.
  - start sampled during DONE is ignored.
- start while busy is ignored; it is not queued.
- abort=1 in any state:
  - Next cycle: IDLE, addr=IDLE_ADDR, out_valid=0, out_sof=0, out_eof=0, busy=0, done=0.
  - A byte being offered in the same cycle as abort is treated as not transferred.
- Timing, start sampled at edge k:
  - addr=FIRST_ADDR after edge k.
  - First out_valid after edge k+SETTLE_CYC+1.
- With out_ready held high:
  - One byte per SETTLE_CYC+2 cycles.
  - Frame = 24*(SETTLE_CYC+2) cycles after start, then a 1-cycle done pulse.
- addr increments by 1 only and never exceeds LAST_ADDR inside a frame, so there is no wrap.
- data_in is sampled only on the capture cycle.
- A mid-frame reset returns the block to the reset values immediately, with no done pulse.

Decomposition:
- Shared package tdc_regmap_pkg holds:
  - FIRST_ADDR, LAST_ADDR, IDLE_ADDR.
  - Map constants ADDR_FPGA=0, ADDR_VER0=1, ADDR_PENC=6, ADDR_CNTR0=7, ADDR_DAC=23.
  - The state encoding IDLE/SETTLE/SEND/DONE.
- gen_sel_signals uses the same package.
- Single module, no sub-module. The settle counter is inline.

Test Plan:
- Frame, no backpressure: SETTLE_CYC=2, out_ready=1, data_in=addr+0x40, start pulse at cycle 0.
  - 24 bytes 0x40..0x57, one every 4 cycles.
  - out_sof only on 0x40, out_eof only on 0x57.
  - done at cycle 97; addr=31 before and after the frame.
- Backpressure: out_ready=0 for 10 cycles on the byte for addr 7.
  - out_valid stays 1 and out_data=0x47 stable; addr stays 7 throughout.
  - Release -> next byte 0x48, no loss and no duplicate.
- Start while busy: start pulses at cycles 20 and 50.
  - Exactly 24 bytes and one done.
  - A start in the cycle after done begins a new frame.
- Abort: abort at the 10th byte's SEND cycle.
  - Next cycle: addr=31, out_valid=0, busy=0, no done.
  - A new start gives a full frame from addr 0.
- Async reset mid-SETTLE: rst_n low between clock edges.
  - All outputs go to reset values without a clock edge.
  - After release, IDLE with addr=31.
- SETTLE_CYC=0: capture occurs on the first SETTLE cycle.
  - 2 cycles per byte with out_ready=1.
  - data_in changed one cycle after the capture cycle is not observed on out_data.
